// File: rtl/trigger_sequencer.sv
// rtl/trigger_sequencer.sv - multi-stage value/edge trigger with per-stage post-match delay
//
// Evaluates a chain of value/edge conditions on valid samples, in order, and
// raises run once the last programmed stage has matched and its delay expired.
//
// Ports:
//   clock          system clock, rising edge
//   reset_n        asynchronous active-low reset (clears config as well)
//   load_trigs     config write strobe, ignored while arm=1
//   cfg_addr       {stage index, field[2:0]}
//   cfg_data       config word, LSBs used
//   arm            level; 1 evaluates samples, 0 returns to idle
//   valid          sample qualifier
//   dataIn         sample data
//   run            trigger fired; sticky while arm stays 1
//   armed          1 while stages are being evaluated or a delay is counting
//   current_stage  index of the stage being evaluated
module trigger_sequencer #(
  parameter int SAMPLE_WIDTH = 8,
  parameter int NUM_STAGES   = 4,
  parameter int DELAY_WIDTH  = 16
) (
  input  logic                            clock,
  input  logic                            reset_n,
  input  logic                            load_trigs,
  input  logic [$clog2(NUM_STAGES)+2:0]   cfg_addr,
  input  logic [31:0]                     cfg_data,
  input  logic                            arm,
  input  logic                            valid,
  input  logic [SAMPLE_WIDTH-1:0]         dataIn,
  output logic                            run,
  output logic                            armed,
  output logic [$clog2(NUM_STAGES)-1:0]   current_stage
);

  localparam int SW = $clog2(NUM_STAGES);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    STAGE = 2'd1,
    DELAY = 2'd2,
    FIRED = 2'd3
  } state_t;

  state_t                  state;
  logic [SAMPLE_WIDTH-1:0] value_mask [NUM_STAGES];
  logic [SAMPLE_WIDTH-1:0] value_cfg  [NUM_STAGES];
  logic [SAMPLE_WIDTH-1:0] rise_mask  [NUM_STAGES];
  logic [SAMPLE_WIDTH-1:0] fall_mask  [NUM_STAGES];
  logic [DELAY_WIDTH-1:0]  delay_cfg  [NUM_STAGES];
  logic [SW-1:0]           last_stage;

  logic [SAMPLE_WIDTH-1:0] prev;
  logic                    prev_ok;
  logic                    arm_d;
  logic [DELAY_WIDTH-1:0]  cnt;

  logic [SW-1:0]           cfg_stage;
  logic [2:0]              cfg_field;
  logic                    unused_cfg;

  assign cfg_stage  = cfg_addr[SW+2:3];
  assign cfg_field  = cfg_addr[2:0];
  assign unused_cfg = ^cfg_data;

  // Configuration registers; frozen while a capture is armed.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int s = 0; s < NUM_STAGES; s++) begin
        value_mask[s] <= '0;
        value_cfg[s]  <= '0;
        rise_mask[s]  <= '0;
        fall_mask[s]  <= '0;
        delay_cfg[s]  <= '0;
      end
      last_stage <= SW'(NUM_STAGES - 1);
    end else if (load_trigs && !arm) begin
      case (cfg_field)
        3'd0: value_mask[cfg_stage] <= cfg_data[SAMPLE_WIDTH-1:0];
        3'd1: value_cfg[cfg_stage]  <= cfg_data[SAMPLE_WIDTH-1:0];
        3'd2: rise_mask[cfg_stage]  <= cfg_data[SAMPLE_WIDTH-1:0];
        3'd3: fall_mask[cfg_stage]  <= cfg_data[SAMPLE_WIDTH-1:0];
        3'd4: delay_cfg[cfg_stage]  <= cfg_data[DELAY_WIDTH-1:0];
        3'd7: begin
          if (cfg_data > 32'(NUM_STAGES - 1))
            last_stage <= SW'(NUM_STAGES - 1);
          else
            last_stage <= cfg_data[SW-1:0];
        end
        default: ;
      endcase
    end
  end

  // Stage match for the stage currently selected.
  logic [SAMPLE_WIDTH-1:0] rises, falls, rm, fm;
  logic                    value_ok, rise_ok, fall_ok, match;
  logic [DELAY_WIDTH-1:0]  stage_delay;

  assign rm          = rise_mask[current_stage];
  assign fm          = fall_mask[current_stage];
  assign stage_delay = delay_cfg[current_stage];
  assign rises       = ~prev & dataIn;
  assign falls       = prev & ~dataIn;
  assign value_ok    = ((dataIn ^ value_cfg[current_stage]) & value_mask[current_stage]) == '0;
  // Edge terms are false until a previous sample exists, so any set edge bit blocks the match.
  assign rise_ok     = (rm == '0) || (prev_ok && ((rm & ~rises) == '0));
  assign fall_ok     = (fm == '0) || (prev_ok && ((fm & ~falls) == '0));
  assign match       = valid && value_ok && rise_ok && fall_ok;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      run           <= 1'b0;
      armed         <= 1'b0;
      current_stage <= '0;
      cnt           <= '0;
      prev          <= '0;
      prev_ok       <= 1'b0;
      arm_d         <= 1'b0;
    end else begin
      arm_d <= arm;
      if (!arm) begin
        state         <= IDLE;
        run           <= 1'b0;
        armed         <= 1'b0;
        current_stage <= '0;
        cnt           <= '0;
        prev_ok       <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            // Only a fresh 0->1 arm starts a capture; a held arm after FIRED does not.
            if (!arm_d) begin
              state         <= STAGE;
              armed         <= 1'b1;
              current_stage <= '0;
              prev_ok       <= 1'b0;
            end
          end
          STAGE: begin
            if (valid) begin
              prev    <= dataIn;
              prev_ok <= 1'b1;
              if (match) begin
                if (stage_delay != '0) begin
                  state <= DELAY;
                  cnt   <= stage_delay;
                end else if (current_stage == last_stage) begin
                  state <= FIRED;
                  run   <= 1'b1;
                  armed <= 1'b0;
                end else begin
                  current_stage <= current_stage + SW'(1);
                end
              end
            end
          end
          DELAY: begin
            if (valid) begin
              prev    <= dataIn;
              prev_ok <= 1'b1;
              cnt     <= cnt - DELAY_WIDTH'(1);
              if (cnt == DELAY_WIDTH'(1)) begin
                if (current_stage == last_stage) begin
                  state <= FIRED;
                  run   <= 1'b1;
                  armed <= 1'b0;
                end else begin
                  // Re-entering STAGE: edge history restarts from the next valid sample.
                  state         <= STAGE;
                  current_stage <= current_stage + SW'(1);
                  prev_ok       <= 1'b0;
                end
              end
            end
          end
          FIRED: ;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
